prim_assembler: RTL and testbench

Parametrised successor to the fixed six-word triangle assembler. It consumes the 32-bit AHB word stream and, inside a FRAME_START/FRAME_END bracket, packs every WORDS consecutive words into one primitive. Completed primitives go into a DEPTH-entry output queue, so the AHB side keeps streaming while the downstream rasteriser is busy. It sits between the AHB slave read buffer and the primitive consumer (rasteriser or vertex transform).

---
 rtl/prim_assembler_if.sv | 30 +++
 rtl/prim_assembler.sv | 137 +++++++++++++
 tb/tb_prim_assembler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/prim_assembler_if.sv
// Stream-side and primitive-side signal bundle for prim_assembler.
// The assembler connects through the slave modport; the producer/consumer side uses master.
interface prim_assembler_if #(
  parameter int unsigned WORDS = 6,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]         ahb_buffer;
  logic                ahb_data_available;
  logic                ahb_user_read_buffer;
  logic                prim_read;
  logic                prim_ready;
  logic [WORDS*32-1:0] prim_data;
  logic [CNT_W-1:0]    prim_count;
  logic                frame_active;
  logic                frame_done;

  modport slave (
    input  ahb_buffer, ahb_data_available, prim_read,
    output ahb_user_read_buffer, prim_ready, prim_data, prim_count,
           frame_active, frame_done
  );

  modport master (
    output ahb_buffer, ahb_data_available, prim_read,
    input  ahb_user_read_buffer, prim_ready, prim_data, prim_count,
           frame_active, frame_done
  );
endinterface

// File: rtl/prim_assembler.sv
// Packs WORDS-word groups of the AHB stream, inside a FRAME_START/FRAME_END bracket,
// into primitives held in a DEPTH-entry circular output queue.
module prim_assembler #(
  parameter int unsigned WORDS       = 6,
  parameter int unsigned DEPTH       = 2,
  parameter logic [31:0] FRAME_START = 32'd0,
  parameter logic [31:0] FRAME_END   = 32'd1
) (
  input  logic              clk,
  input  logic              n_rst,
  prim_assembler_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW    = WORDS * 32;

  typedef enum logic [1:0] {IDLE, COLLECT, END_CHK} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   word_idx, word_idx_d;
  logic               done_d, frame_done_q;
  logic               slot_we;
  logic [IDX_W-1:0]   slot_sel;
  logic [31:0]        slot [WORDS-1];
  logic [PW-1:0]      queue [DEPTH];
  logic [PW-1:0]      push_data;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               last_word, full, read_buffer, accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stall only on the completing word, and only if no slot frees up this cycle.
  assign full        = (count == CNT_W'(DEPTH));
  assign last_word   = (state == COLLECT) && (word_idx == IDX_W'(WORDS - 1));
  assign read_buffer = !(last_word && full && !bus.prim_read);
  assign accept      = bus.ahb_data_available && read_buffer;
  assign push        = accept && last_word;
  assign pop         = bus.prim_read && (count != '0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      word_idx     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_d;
      word_idx     <= word_idx_d;
      frame_done_q <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    word_idx_d = word_idx;
    done_d     = 1'b0;
    slot_we    = 1'b0;
    slot_sel   = word_idx;
    case (state)
      IDLE: begin
        if (accept && (bus.ahb_buffer == FRAME_START)) begin
          state_d    = COLLECT;
          word_idx_d = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (last_word) begin
            state_d    = END_CHK;
            word_idx_d = '0;
          end else begin
            slot_we    = 1'b1;
            word_idx_d = word_idx + IDX_W'(1);
          end
        end
      end
      END_CHK: begin
        // Anything but FRAME_END starts the next primitive with no bubble.
        if (accept) begin
          if (bus.ahb_buffer == FRAME_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = COLLECT;
            word_idx_d = IDX_W'(1);
            slot_we    = 1'b1;
            slot_sel   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < int'(WORDS) - 1; k++) slot[k] <= '0;
    end else if (slot_we) begin
      for (int k = 0; k < int'(WORDS) - 1; k++) begin
        if (slot_sel == IDX_W'(k)) slot[k] <= bus.ahb_buffer;
      end
    end
  end

  // The completing word bypasses the slots and goes straight into the queue entry.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < int'(WORDS) - 1; k++) push_data[32*k +: 32] = slot[k];
    push_data[PW-1 -: 32] = bus.ahb_buffer;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < int'(DEPTH); k++) queue[k] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        queue[wr_ptr] <= push_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign bus.ahb_user_read_buffer = read_buffer;
  assign bus.prim_ready           = (count != '0);
  assign bus.prim_data            = (count != '0) ? queue[rd_ptr] : '0;
  assign bus.prim_count           = count;
  assign bus.frame_active         = (state != IDLE);
  assign bus.frame_done           = frame_done_q;
endmodule

// File: tb/tb_prim_assembler.sv
// Directed bench for prim_assembler (WORDS=6, DEPTH=2): vector table plus
// hand-written backpressure, full push/pop wrap and mid-frame reset sequences.
module tb_prim_assembler;
  localparam int unsigned WORDS = 6;
  localparam int unsigned DEPTH = 2;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  prim_assembler_if #(.WORDS(WORDS), .DEPTH(DEPTH)) bus ();

  prim_assembler #(
    .WORDS(WORDS), .DEPTH(DEPTH), .FRAME_START(32'd0), .FRAME_END(32'd1)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        avail;
    logic [31:0] data;
    logic        rd;
    logic        rb;
    logic        ready;
    int          cnt;
    logic        active;
    logic        done;
    logic [31:0] w0, w2, w3, w5;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic a, input logic [31:0] d, input logic r,
                              input logic rb, input logic rdy, input int c,
                              input logic act, input logic dn,
                              input logic [31:0] w0, input logic [31:0] w2,
                              input logic [31:0] w3, input logic [31:0] w5);
    vec_t v;
    v.avail = a; v.data = d; v.rd = r; v.rb = rb; v.ready = rdy; v.cnt = c;
    v.active = act; v.done = dn; v.w0 = w0; v.w2 = w2; v.w3 = w3; v.w5 = w5;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic r);
    bus.ahb_data_available = a;
    bus.ahb_buffer         = d;
    bus.prim_read          = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int k);
    logic [WORDS*32-1:0] pd;
    pd = bus.prim_data;
    return pd[32*k +: 32];
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] base;
  logic        rd;

  initial begin
    // idle discard, basic frame, pop, empty pop
    vq.push_back(mk(1, 32'hDEAD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'd1,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'd0,    0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      vq.push_back(mk(1, 32'h10 + 32'(k), 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'h16, 0, 1, 1, 1, 1, 0, 32'h11, 32'h13, 32'h14, 32'h16));
    vq.push_back(mk(1, 32'd1,  0, 1, 1, 1, 0, 1, 32'h11, 32'h13, 32'h14, 32'h16));
    vq.push_back(mk(0, 32'd1,  0, 1, 1, 1, 0, 0, 32'h11, 32'h13, 32'h14, 32'h16));
    vq.push_back(mk(0, 32'd0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 32'd0,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // markers as data inside COLLECT
    vq.push_back(mk(1, 32'd0,   0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'hA0,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'hA1,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'd0,   0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'd1,   0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'hA4,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'hA5,  0, 1, 1, 1, 1, 0, 32'hA0, 32'd0, 32'd1, 32'hA5));
    vq.push_back(mk(0, 32'd1,   0, 1, 1, 1, 1, 0, 32'hA0, 32'd0, 32'd1, 32'hA5));
    vq.push_back(mk(1, 32'd1,   0, 1, 1, 1, 0, 1, 32'hA0, 32'd0, 32'd1, 32'hA5));
    vq.push_back(mk(0, 32'd0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // frame with a gap before every word
    vq.push_back(mk(1, 32'd0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      vq.push_back(mk(0, 32'd0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      if (k < 6) vq.push_back(mk(1, 32'h10 + 32'(k), 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      else       vq.push_back(mk(1, 32'h16, 0, 1, 1, 1, 1, 0, 32'h11, 32'h13, 32'h14, 32'h16));
    end
    vq.push_back(mk(1, 32'd1, 0, 1, 1, 1, 0, 1, 32'h11, 32'h13, 32'h14, 32'h16));
    vq.push_back(mk(0, 32'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    n_rst = 1'b0;
    drive(0, 32'd0, 0);
    #12;
    chk("rst rb", 32'(bus.ahb_user_read_buffer), 32'd1);
    chk("rst ready", 32'(bus.prim_ready), 32'd0);
    chk("rst count", 32'(bus.prim_count), 32'd0);
    chk("rst data", 32'(|bus.prim_data), 32'd0);
    chk("rst active", 32'(bus.frame_active), 32'd0);
    chk("rst done", 32'(bus.frame_done), 32'd0);
    n_rst = 1'b1;
    tick;

    foreach (vq[i]) begin
      drive(vq[i].avail, vq[i].data, vq[i].rd);
      #1;
      chk($sformatf("v%0d rb", i), 32'(bus.ahb_user_read_buffer), 32'(vq[i].rb));
      tick;
      chk($sformatf("v%0d ready", i),  32'(bus.prim_ready),   32'(vq[i].ready));
      chk($sformatf("v%0d count", i),  32'(bus.prim_count),   32'(vq[i].cnt));
      chk($sformatf("v%0d active", i), 32'(bus.frame_active), 32'(vq[i].active));
      chk($sformatf("v%0d done", i),   32'(bus.frame_done),   32'(vq[i].done));
      chk($sformatf("v%0d w0", i), word(0), vq[i].w0);
      chk($sformatf("v%0d w2", i), word(2), vq[i].w2);
      chk($sformatf("v%0d w3", i), word(3), vq[i].w3);
      chk($sformatf("v%0d w5", i), word(5), vq[i].w5);
    end
    drive(0, 32'd0, 0);
    tick;

    // back-to-back: third primitive's last word stalls until a pop
    drive(1, 32'd0, 0); tick;
    for (int i = 1; i <= 17; i++) begin
      drive(1, 32'h100 + 32'(i), 0);
      tick;
    end
    chk("bb count full", 32'(bus.prim_count), 32'd2);
    drive(1, 32'h112, 0);
    #1;
    chk("bb stall rb", 32'(bus.ahb_user_read_buffer), 32'd0);
    tick;
    chk("bb stall rb held", 32'(bus.ahb_user_read_buffer), 32'd0);
    chk("bb stall count", 32'(bus.prim_count), 32'd2);
    chk("bb head A", word(0), 32'h101);
    drive(1, 32'h112, 1);
    #1;
    chk("bb release rb", 32'(bus.ahb_user_read_buffer), 32'd1);
    tick;
    chk("bb pushpop count", 32'(bus.prim_count), 32'd2);
    chk("bb head B", word(0), 32'h107);
    drive(1, 32'd1, 0); tick;
    chk("bb done", 32'(bus.frame_done), 32'd1);
    chk("bb active", 32'(bus.frame_active), 32'd0);
    drive(0, 32'd0, 1); tick;
    chk("bb head C w0", word(0), 32'h10D);
    chk("bb head C w5", word(5), 32'h112);
    chk("bb count 1", 32'(bus.prim_count), 32'd1);
    drive(0, 32'd0, 1); tick;
    chk("bb drained", 32'(bus.prim_count), 32'd0);

    // five primitives with a pop on each completing word once full
    drive(1, 32'd0, 0); tick;
    for (int p = 0; p < 5; p++) begin
      base = 32'h300 + 32'(p * 16);
      for (int k = 0; k < 6; k++) begin
        rd = (k == 5) && (p >= 2);
        if (rd) chk($sformatf("wrap pop p%0d head", p), word(0), exp_q[0]);
        drive(1, base + 32'(k), rd);
        tick;
        if (rd) void'(exp_q.pop_front());
      end
      exp_q.push_back(base);
      chk($sformatf("wrap p%0d count", p), 32'(bus.prim_count), (p == 0) ? 32'd1 : 32'd2);
    end
    drive(1, 32'd1, 0); tick;
    while (exp_q.size() > 0) begin
      chk("wrap drain w0", word(0), exp_q[0]);
      chk("wrap drain w5", word(5), exp_q[0] + 32'd5);
      drive(0, 32'd0, 1); tick;
      void'(exp_q.pop_front());
    end
    chk("wrap empty ready", 32'(bus.prim_ready), 32'd0);
    drive(0, 32'd0, 0); tick;

    // reset mid-frame with one queued primitive
    drive(1, 32'd0, 0); tick;
    for (int i = 1; i <= 9; i++) begin
      drive(1, 32'h400 + 32'(i), 0);
      tick;
    end
    chk("mid count", 32'(bus.prim_count), 32'd1);
    chk("mid active", 32'(bus.frame_active), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("mrst rb", 32'(bus.ahb_user_read_buffer), 32'd1);
    chk("mrst ready", 32'(bus.prim_ready), 32'd0);
    chk("mrst count", 32'(bus.prim_count), 32'd0);
    chk("mrst data", 32'(|bus.prim_data), 32'd0);
    chk("mrst active", 32'(bus.frame_active), 32'd0);
    chk("mrst done", 32'(bus.frame_done), 32'd0);
    #2 n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h55, 0);
      tick;
    end
    chk("post rst count", 32'(bus.prim_count), 32'd0);
    chk("post rst active", 32'(bus.frame_active), 32'd0);
    chk("post rst ready", 32'(bus.prim_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
